// File: rtl/store_byte_merger.sv
// Store unit that turns byte stores into read-modify-write word accesses and
// issues aligned word stores directly, with a per-access response timeout.
module store_byte_merger #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic [31:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        mem_wr_en,
    output logic [31:0] mem_wdata,
    input  logic        mem_wack,
    output logic        done,
    output logic        err,
    output logic [1:0]  dbg_state
);

    // Handshake: a request transfers on the rising edge where req_valid and
    // req_ready are both high; req_ready is high only in IDLE, and the request
    // fields are sampled on that edge only.
    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

    localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic [7:0]  bdata_q, bdata_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] maddr_q, maddr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] merged;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            lane_q  <= 2'b00;
            bdata_q <= 8'h00;
            wdata_q <= 32'h0;
            maddr_q <= 32'h0;
            cnt_q   <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            bdata_q <= bdata_d;
            wdata_q <= wdata_d;
            maddr_q <= maddr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        merged = mem_rdata;
        case (lane_q)
            2'b00:   merged[7:0]   = bdata_q;
            2'b01:   merged[15:8]  = bdata_q;
            2'b10:   merged[23:16] = bdata_q;
            default: merged[31:24] = bdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        bdata_d = bdata_q;
        wdata_d = wdata_q;
        maddr_d = maddr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    lane_d  = req_addr[1:0];
                    bdata_d = req_data[7:0];
                    cnt_d   = 8'h00;
                    err_d   = 1'b0;
                    if (req_byte) begin
                        state_d = RD;
                        maddr_d = {req_addr[31:2], 2'b00};
                    end else if (req_addr[1:0] == 2'b00) begin
                        state_d = WR;
                        wdata_d = req_data;
                        maddr_d = {req_addr[31:2], 2'b00};
                    end else begin
                        // Misaligned word store: report failure, touch no memory.
                        state_d = FIN;
                        err_d   = 1'b1;
                    end
                end
            end
            RD: begin
                if (mem_rvalid) begin
                    state_d = WR;
                    wdata_d = merged;
                    cnt_d   = 8'h00;
                end else if (cnt_q == TMAX) begin
                    state_d = FIN;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WR: begin
                // A response wins over a timeout firing in the same cycle.
                if (mem_wack) begin
                    state_d = FIN;
                    err_d   = 1'b0;
                end else if (cnt_q == TMAX) begin
                    state_d = FIN;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign mem_rd_en = (state_q == RD);
    assign mem_wr_en = (state_q == WR);
    assign done      = (state_q == FIN);
    assign err       = (state_q == FIN) && err_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = wdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_store_byte_merger.sv
// Directed bench for store_byte_merger: byte merges in every lane, word and
// misaligned stores, read timeout with and without a last-cycle response, reset abort.
module tb_store_byte_merger;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_byte;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;
    logic        mem_wack;
    logic        done;
    logic        err;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    int overlap = 0;
    logic [31:0] exp_q[$];

    store_byte_merger #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_byte(req_byte),
        .req_addr(req_addr), .req_data(req_data),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
        .mem_wack(mem_wack), .done(done), .err(err), .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (mem_rd_en && mem_wr_en) overlap++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Driver: issue one request and play a memory that answers reads on the
    // rd_resp-th read cycle (0 = never) and acknowledges writes at once.
    // Cycle numbers are counted from the acceptance edge (edge 0).
    task automatic run_store(input logic byt, input logic [31:0] addr, input logic [31:0] data,
                             input logic [31:0] rdata, input int rd_resp,
                             output int n_rd, output int n_wr, output int first_rd,
                             output int first_wr, output int done_cyc, output logic err_v,
                             output logic [31:0] raddr_v, output logic [31:0] waddr_v);
        n_rd = 0; n_wr = 0; first_rd = -1; first_wr = -1; done_cyc = -1;
        err_v = 1'b0; raddr_v = 32'hx; waddr_v = 32'hx;
        req_valid = 1'b1; req_byte = byt; req_addr = addr; req_data = data;
        mem_rdata = rdata; mem_rvalid = 1'b0; mem_wack = 1'b0;
        cycle();
        req_valid = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            mem_rvalid = 1'b0;
            mem_wack   = 1'b0;
            if (mem_rd_en) begin
                n_rd++;
                if (first_rd < 0) first_rd = cyc;
                raddr_v = mem_addr;
                mem_rvalid = (n_rd == rd_resp);
            end
            if (mem_wr_en) begin
                n_wr++;
                if (first_wr < 0) first_wr = cyc;
                waddr_v = mem_addr;
                mem_wack = 1'b1;
                if (exp_q.size() == 0) chk("unexpected_write", mem_wdata, 32'hx);
                else chk("wdata", mem_wdata, exp_q.pop_front());
            end
            if (done) begin
                done_cyc = cyc;
                err_v = err;
                cycle();
                break;
            end
            cycle();
        end
        mem_rvalid = 1'b0;
        mem_wack   = 1'b0;
        if (done_cyc < 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    int n_rd, n_wr, f_rd, f_wr, d_cyc;
    logic e_v;
    logic [31:0] ra, wa;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_byte = 1'b0; req_addr = '0; req_data = '0;
        mem_rdata = '0; mem_rvalid = 1'b0; mem_wack = 1'b0;
        cycle(); cycle();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        cycle();

        // Byte store, lane 2
        exp_q.push_back(32'h11AB3344);
        run_store(1'b1, 32'h00001002, 32'h000000AB, 32'h11223344, 1,
                  n_rd, n_wr, f_rd, f_wr, d_cyc, e_v, ra, wa);
        chk("b2_rd_addr", ra, 32'h00001000);
        chk("b2_first_rd", f_rd, 32'd1);
        chk("b2_n_rd", n_rd, 32'd1);
        chk("b2_first_wr", f_wr, 32'd2);
        chk("b2_wr_addr", wa, 32'h00001000);
        chk("b2_done_cyc", d_cyc, 32'd3);
        chk("b2_err", {31'd0, e_v}, 32'd0);
        chk("b2_idle_ready", {31'd0, req_ready}, 32'd1);
        chk("b2_idle_done", {31'd0, done}, 32'd0);

        // Lane 3 with junk in the upper data bits, lane 0, lane 1
        exp_q.push_back(32'h77FFFFFF);
        run_store(1'b1, 32'h00000003, 32'hABCDEF77, 32'hFFFFFFFF, 1,
                  n_rd, n_wr, f_rd, f_wr, d_cyc, e_v, ra, wa);
        chk("b3_wr_addr", wa, 32'h00000000);
        exp_q.push_back(32'hFFFFFF77);
        run_store(1'b1, 32'h00000000, 32'h00000077, 32'hFFFFFFFF, 1,
                  n_rd, n_wr, f_rd, f_wr, d_cyc, e_v, ra, wa);
        chk("b0_err", {31'd0, e_v}, 32'd0);
        exp_q.push_back(32'h00001200);
        run_store(1'b1, 32'h00000105, 32'h00000012, 32'h00000000, 1,
                  n_rd, n_wr, f_rd, f_wr, d_cyc, e_v, ra, wa);
        chk("b1_rd_addr", ra, 32'h00000104);

        // Aligned word store
        exp_q.push_back(32'hDEADBEEF);
        run_store(1'b0, 32'h00002000, 32'hDEADBEEF, 32'h0, 0,
                  n_rd, n_wr, f_rd, f_wr, d_cyc, e_v, ra, wa);
        chk("w_n_rd", n_rd, 32'd0);
        chk("w_first_wr", f_wr, 32'd1);
        chk("w_wr_addr", wa, 32'h00002000);
        chk("w_done_cyc", d_cyc, 32'd2);
        chk("w_err", {31'd0, e_v}, 32'd0);

        // Misaligned word store
        run_store(1'b0, 32'h00002001, 32'h12345678, 32'h0, 0,
                  n_rd, n_wr, f_rd, f_wr, d_cyc, e_v, ra, wa);
        chk("mis_n_rd", n_rd, 32'd0);
        chk("mis_n_wr", n_wr, 32'd0);
        chk("mis_done_cyc", d_cyc, 32'd1);
        chk("mis_err", {31'd0, e_v}, 32'd1);
        chk("mis_err_after", {31'd0, err}, 32'd0);
        chk("mis_addr_held", mem_addr, 32'h00002000);

        // Read timeout, then a response in the last allowed cycle
        run_store(1'b1, 32'h00000010, 32'h00000055, 32'hA0A0A0A0, 0,
                  n_rd, n_wr, f_rd, f_wr, d_cyc, e_v, ra, wa);
        chk("to_n_rd", n_rd, 32'd4);
        chk("to_n_wr", n_wr, 32'd0);
        chk("to_done_cyc", d_cyc, 32'd5);
        chk("to_err", {31'd0, e_v}, 32'd1);
        exp_q.push_back(32'hA0A0A055);
        run_store(1'b1, 32'h00000010, 32'h00000055, 32'hA0A0A0A0, 4,
                  n_rd, n_wr, f_rd, f_wr, d_cyc, e_v, ra, wa);
        chk("late_n_rd", n_rd, 32'd4);
        chk("late_n_wr", n_wr, 32'd1);
        chk("late_done_cyc", d_cyc, 32'd6);
        chk("late_err", {31'd0, e_v}, 32'd0);

        // Reset in the middle of a read
        req_valid = 1'b1; req_byte = 1'b1; req_addr = 32'h00004001; req_data = 32'h99;
        cycle();
        req_valid = 1'b0;
        chk("ra_rd_before", {31'd0, mem_rd_en}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("ra_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("ra_req_ready", {31'd0, req_ready}, 32'd1);
        chk("ra_mem_addr", mem_addr, 32'd0);
        cycle();
        chk("ra_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        cycle();
        chk("ra_after_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("ra_after_done", {31'd0, done}, 32'd0);
        exp_q.push_back(32'hCAFEF00D);
        run_store(1'b0, 32'h00003000, 32'hCAFEF00D, 32'h0, 0,
                  n_rd, n_wr, f_rd, f_wr, d_cyc, e_v, ra, wa);
        chk("ra_w_done_cyc", d_cyc, 32'd2);
        chk("ra_w_err", {31'd0, e_v}, 32'd0);
        chk("ra_w_addr", wa, 32'h00003000);

        chk("rd_wr_overlap", overlap, 32'd0);
        chk("exp_q_left", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
